// File: rtl/pipe_dest_tracker_if.sv
// Signal bundle between the decode stage and the destination tracker.
// The master side drives ID-stage fields; the slave side reports hazard and pipeline state.
interface pipe_dest_tracker_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;

  logic        stall;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic        id_ex_regwrite;
  logic        id_ex_memread;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_regwrite;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
    input  stall, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regwrite, id_ex_memread,
    input  ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
    output stall, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regwrite, id_ex_memread,
    output ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite, stall_cnt
  );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Tracks destination registers through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards, inserts bubbles and counts stalled cycles.
module pipe_dest_tracker (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_dest_tracker_if.slave   io_pipe
);

  logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
  logic        r_idex_regwrite, r_idex_memread;
  logic [4:0]  r_exmem_rd;
  logic        r_exmem_regwrite;
  logic [4:0]  r_memwb_rd;
  logic        r_memwb_regwrite;
  logic [15:0] r_stall_cnt;

  logic        w_hazard;
  logic        w_stall;
  logic        w_bubble;
  logic [4:0]  w_idex_rs1_d, w_idex_rs2_d, w_idex_rd_d;
  logic        w_idex_regwrite_d, w_idex_memread_d;
  logic [15:0] w_stall_cnt_d;

  // A load in EX whose result ID needs cannot forward in time; x0 never creates a hazard.
  always_comb begin
    w_hazard = r_idex_memread && (r_idex_rd != 5'd0) &&
               ((r_idex_rd == io_pipe.id_rs1) || (r_idex_rd == io_pipe.id_rs2));
    w_stall  = io_pipe.id_valid && w_hazard && !io_pipe.flush;
    w_bubble = io_pipe.flush || w_stall || !io_pipe.id_valid;
  end

  always_comb begin
    w_idex_rs1_d      = 5'd0;
    w_idex_rs2_d      = 5'd0;
    w_idex_rd_d       = 5'd0;
    w_idex_regwrite_d = 1'b0;
    w_idex_memread_d  = 1'b0;
    if (!w_bubble) begin
      w_idex_rs1_d      = io_pipe.id_rs1;
      w_idex_rs2_d      = io_pipe.id_rs2;
      w_idex_rd_d       = io_pipe.id_rd;
      w_idex_regwrite_d = io_pipe.id_regwrite && (io_pipe.id_rd != 5'd0);
      w_idex_memread_d  = io_pipe.id_memread;
    end
  end

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      w_stall_cnt_d = r_stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_rs1       <= 5'd0;
      r_idex_rs2       <= 5'd0;
      r_idex_rd        <= 5'd0;
      r_idex_regwrite  <= 1'b0;
      r_idex_memread   <= 1'b0;
      r_exmem_rd       <= 5'd0;
      r_exmem_regwrite <= 1'b0;
      r_memwb_rd       <= 5'd0;
      r_memwb_regwrite <= 1'b0;
      r_stall_cnt      <= 16'd0;
    end else begin
      r_idex_rs1       <= w_idex_rs1_d;
      r_idex_rs2       <= w_idex_rs2_d;
      r_idex_rd        <= w_idex_rd_d;
      r_idex_regwrite  <= w_idex_regwrite_d;
      r_idex_memread   <= w_idex_memread_d;
      // Later stages never freeze: the stalled load must keep draining.
      r_exmem_rd       <= r_idex_rd;
      r_exmem_regwrite <= r_idex_regwrite;
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_regwrite <= r_exmem_regwrite;
      r_stall_cnt      <= w_stall_cnt_d;
    end
  end

  assign io_pipe.stall           = w_stall;
  assign io_pipe.id_ex_rs1       = r_idex_rs1;
  assign io_pipe.id_ex_rs2       = r_idex_rs2;
  assign io_pipe.id_ex_rd        = r_idex_rd;
  assign io_pipe.id_ex_regwrite  = r_idex_regwrite;
  assign io_pipe.id_ex_memread   = r_idex_memread;
  assign io_pipe.ex_mem_rd       = r_exmem_rd;
  assign io_pipe.ex_mem_regwrite = r_exmem_regwrite;
  assign io_pipe.mem_wb_rd       = r_memwb_rd;
  assign io_pipe.mem_wb_regwrite = r_memwb_regwrite;
  assign io_pipe.stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed bench for pipe_dest_tracker: load-use, x0, flush priority, shift,
// counter saturation and asynchronous reset.
module tb_pipe_dest_tracker;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pipe_dest_tracker_if u_if ();

  pipe_dest_tracker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_pipe (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    u_if.id_valid    = v;
    u_if.id_rs1      = rs1;
    u_if.id_rs2      = rs2;
    u_if.id_rd       = rd;
    u_if.id_regwrite = rw;
    u_if.id_memread  = mr;
    u_if.flush       = fl;
  endtask

  // Drive at the falling edge, let the outputs settle, then advance past the rising edge.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    edge_step();
    edge_step();
    chk("rst_stall", {15'd0, u_if.stall}, 16'd0);
    chk("rst_id_ex_rd", {11'd0, u_if.id_ex_rd}, 16'd0);
    chk("rst_ex_mem_regwrite", {15'd0, u_if.ex_mem_regwrite}, 16'd0);
    chk("rst_stall_cnt", u_if.stall_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: lw x5, then an instruction reading x5 on rs2.
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
    #1 chk("lu_load_stall", {15'd0, u_if.stall}, 16'd0);
    edge_step();
    chk("lu_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd5);
    chk("lu_idex_memread", {15'd0, u_if.id_ex_memread}, 16'd1);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", {15'd0, u_if.stall}, 16'd1);
    edge_step();
    chk("lu_bubble_rd", {11'd0, u_if.id_ex_rd}, 16'd0);
    chk("lu_bubble_memread", {15'd0, u_if.id_ex_memread}, 16'd0);
    chk("lu_stall_cnt", u_if.stall_cnt, 16'd1);
    chk("lu_ex_mem_rd", {11'd0, u_if.ex_mem_rd}, 16'd5);
    chk("lu_ex_mem_regwrite", {15'd0, u_if.ex_mem_regwrite}, 16'd1);
    @(negedge clk);
    #1 chk("lu_stall_released", {15'd0, u_if.stall}, 16'd0);
    edge_step();
    chk("lu_dep_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd6);
    chk("lu_dep_idex_rs2", {11'd0, u_if.id_ex_rs2}, 16'd5);
    chk("lu_mem_wb_rd", {11'd0, u_if.mem_wb_rd}, 16'd5);
    chk("lu_ex_mem_bubble", {11'd0, u_if.ex_mem_rd}, 16'd0);

    // x0: load to x0 never stalls; non-load to x0 never reports a write.
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    edge_step();
    chk("x0_load_regwrite", {15'd0, u_if.id_ex_regwrite}, 16'd0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_no_stall", {15'd0, u_if.stall}, 16'd0);
    edge_step();
    chk("x0_dep_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd8);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("x0_alu_regwrite", {15'd0, u_if.id_ex_regwrite}, 16'd0);
    chk("x0_ex_mem_rd", {11'd0, u_if.ex_mem_rd}, 16'd8);

    // Flush beats stall.
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    edge_step();
    chk("fl_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd7);
    @(negedge clk);
    drive(1'b1, 5'd7, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    #1 chk("fl_stall", {15'd0, u_if.stall}, 16'd0);
    edge_step();
    chk("fl_bubble_rd", {11'd0, u_if.id_ex_rd}, 16'd0);
    chk("fl_bubble_rs1", {11'd0, u_if.id_ex_rs1}, 16'd0);
    chk("fl_stall_cnt", u_if.stall_cnt, 16'd1);
    chk("fl_ex_mem_rd", {11'd0, u_if.ex_mem_rd}, 16'd7);

    // Shift: x9 walks ID/EX -> EX/MEM -> MEM/WB.
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("sh_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd9);
    chk("sh_idex_rw", {15'd0, u_if.id_ex_regwrite}, 16'd1);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("sh_exmem_rd", {11'd0, u_if.ex_mem_rd}, 16'd9);
    chk("sh_exmem_rw", {15'd0, u_if.ex_mem_regwrite}, 16'd1);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("sh_memwb_rd", {11'd0, u_if.mem_wb_rd}, 16'd9);
    chk("sh_memwb_rw", {15'd0, u_if.mem_wb_regwrite}, 16'd1);
    chk("sh_exmem_next", {11'd0, u_if.ex_mem_rd}, 16'd10);
    @(negedge clk);
    drive(1'b0, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("inv_bubble_rd", {11'd0, u_if.id_ex_rd}, 16'd0);
    chk("inv_bubble_rw", {15'd0, u_if.id_ex_regwrite}, 16'd0);

    // Saturation: deposit near the top, then three real stalls.
    @(negedge clk);
    dut.r_stall_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
      edge_step();
      @(negedge clk);
      drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 chk("sat_stall", {15'd0, u_if.stall}, 16'd1);
      edge_step();
      chk("sat_stall_cnt", u_if.stall_cnt, 16'hFFFF);
    end

    // Async reset while stalled.
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0);
    edge_step();
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1 chk("ar_stall_before", {15'd0, u_if.stall}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_stall", {15'd0, u_if.stall}, 16'd0);
    chk("ar_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd0);
    chk("ar_idex_memread", {15'd0, u_if.id_ex_memread}, 16'd0);
    chk("ar_exmem_rd", {11'd0, u_if.ex_mem_rd}, 16'd0);
    chk("ar_memwb_rd", {11'd0, u_if.mem_wb_rd}, 16'd0);
    chk("ar_stall_cnt", u_if.stall_cnt, 16'd0);
    edge_step();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_post_stall", {15'd0, u_if.stall}, 16'd0);
    edge_step();
    chk("ar_post_idex_rd", {11'd0, u_if.id_ex_rd}, 16'd6);
    chk("ar_post_stall_cnt", u_if.stall_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
